// File: rtl/sample_hit_buffer_pkg.sv
// Rasteriser parameters shared by the sample-hit buffer and its FIFO.
// A fragment is stored in the buffer as one frag_t word.
package sample_hit_buffer_pkg;
    localparam int SIGFIG     = 24;
    localparam int RADIX      = 10;
    localparam int COLORS     = 3;
    localparam int FRAG_DEPTH = 8;
    localparam int PIPES_HASH = 2;
    localparam int PIPES_SAMP = 2;
    localparam int SLACK      = PIPES_HASH + PIPES_SAMP;

    typedef struct packed {
        logic [SIGFIG-1:0]             x;
        logic [SIGFIG-1:0]             y;
        logic [SIGFIG-1:0]             z;
        logic [COLORS-1:0][SIGFIG-1:0] color;
    } frag_t;
endpackage

// File: rtl/frag_fifo.sv
// First-word-fall-through FIFO. The head entry is held in a register so the
// downstream sees registered data and a registered non-empty flag.
module frag_fifo
    import sample_hit_buffer_pkg::*;
#(
    parameter int  DEPTH = FRAG_DEPTH,
    parameter type T     = frag_t,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          rd,
    input  T              din,
    output T              head,
    output logic          not_empty,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nx;
    logic [CW-1:0] count_after_rd;
    T              mem [DEPTH];

    assign count_next     = count + CW'(wr) - CW'(rd);
    assign count_after_rd = count - CW'(rd);
    assign rd_ptr_nx      = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            not_empty <= 1'b0;
            head      <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr_nx;
            count     <= count_next;
            not_empty <= (count_next != '0);
            // An entry written into an otherwise-empty FIFO goes straight to
            // the head; after a read the head reloads from the next slot,
            // which a same-cycle write never targets.
            if (wr && count_after_rd == '0)
                head <= din;
            else if (rd)
                head <= mem[rd_ptr_nx];
        end
    end
endmodule

// File: rtl/sample_hit_buffer.sv
// Buffers hit fragments from the sample pipeline and drains them to the
// z/frame-buffer writer; halts upstream early enough to absorb in-flight hits.
module sample_hit_buffer
    import sample_hit_buffer_pkg::*;
#(
    parameter int  DEPTH = FRAG_DEPTH,
    parameter int  SLK   = SLACK,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hit_valid_in,
    input  logic [SIGFIG-1:0]        hit_x_in,
    input  logic [SIGFIG-1:0]        hit_y_in,
    input  logic [SIGFIG-1:0]        hit_z_in,
    input  logic [COLORS*SIGFIG-1:0] hit_color_in,
    output logic                     halt_L,
    output logic                     frag_valid,
    input  logic                     frag_ready,
    output logic [SIGFIG-1:0]        frag_x,
    output logic [SIGFIG-1:0]        frag_y,
    output logic [SIGFIG-1:0]        frag_z,
    output logic [COLORS*SIGFIG-1:0] frag_color,
    output logic [CW-1:0]            occupancy,
    output logic                     overflow_err
);
    frag_t         din;
    frag_t         head;
    logic          rd;
    logic          wr;
    logic          full;
    logic [CW-1:0] count_next;

    assign din  = {hit_x_in, hit_y_in, hit_z_in, hit_color_in};
    assign full = (occupancy == CW'(DEPTH));
    assign rd   = frag_valid & frag_ready;
    assign wr   = hit_valid_in & (~full | rd);

    frag_fifo #(.DEPTH(DEPTH), .T(frag_t)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .rd        (rd),
        .din       (din),
        .head      (head),
        .not_empty (frag_valid),
        .count     (occupancy),
        .count_next(count_next)
    );

    assign frag_x     = head.x;
    assign frag_y     = head.y;
    assign frag_z     = head.z;
    assign frag_color = head.color;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_L       <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            halt_L <= (count_next < CW'(DEPTH - SLK));
            if (hit_valid_in && full && !rd) overflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sample_hit_buffer.sv
// Directed and randomised checks of sample_hit_buffer against a queue model.
module tb_sample_hit_buffer;
    import sample_hit_buffer_pkg::*;

    localparam int DEPTH = FRAG_DEPTH;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     hit_valid_in = 1'b0;
    logic [SIGFIG-1:0]        hit_x_in = '0;
    logic [SIGFIG-1:0]        hit_y_in = '0;
    logic [SIGFIG-1:0]        hit_z_in = '0;
    logic [COLORS*SIGFIG-1:0] hit_color_in = '0;
    logic                     halt_L;
    logic                     frag_valid;
    logic                     frag_ready = 1'b0;
    logic [SIGFIG-1:0]        frag_x;
    logic [SIGFIG-1:0]        frag_y;
    logic [SIGFIG-1:0]        frag_z;
    logic [COLORS*SIGFIG-1:0] frag_color;
    logic [CW-1:0]            occupancy;
    logic                     overflow_err;

    always #5 clk = ~clk;

    sample_hit_buffer dut (
        .clk(clk), .rst(rst), .hit_valid_in(hit_valid_in),
        .hit_x_in(hit_x_in), .hit_y_in(hit_y_in), .hit_z_in(hit_z_in),
        .hit_color_in(hit_color_in), .halt_L(halt_L), .frag_valid(frag_valid),
        .frag_ready(frag_ready), .frag_x(frag_x), .frag_y(frag_y),
        .frag_z(frag_z), .frag_color(frag_color), .occupancy(occupancy),
        .overflow_err(overflow_err)
    );

    int    total = 0;
    int    bad   = 0;
    frag_t q[$];
    bit    m_ovf  = 1'b0;
    bit    m_halt = 1'b1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("frag_valid", 128'(frag_valid), 128'(q.size() != 0));
        chk("occupancy", 128'(occupancy), 128'(q.size()));
        chk("halt_L", 128'(halt_L), 128'(m_halt));
        chk("overflow_err", 128'(overflow_err), 128'(m_ovf));
        if (q.size() != 0) begin
            chk("frag_x", 128'(frag_x), 128'(q[0].x));
            chk("frag_y", 128'(frag_y), 128'(q[0].y));
            chk("frag_z", 128'(frag_z), 128'(q[0].z));
            chk("frag_color", 128'(frag_color), 128'(q[0].color));
        end
    endtask

    function automatic frag_t rand_frag(input int z);
        frag_t f;
        f.x = SIGFIG'($urandom());
        f.y = SIGFIG'($urandom());
        f.z = SIGFIG'(z);
        for (int c = 0; c < COLORS; c++) f.color[c] = SIGFIG'($urandom());
        return f;
    endfunction

    // Apply inputs for one cycle, advance the model, then check after the edge.
    task automatic step(input bit hv, input frag_t f, input bit rdy);
        bit rd_m;
        bit wr_m;
        hit_valid_in = hv;
        hit_x_in     = f.x;
        hit_y_in     = f.y;
        hit_z_in     = f.z;
        hit_color_in = f.color;
        frag_ready   = rdy;
        rd_m = (q.size() != 0) && rdy;
        wr_m = hv && ((q.size() < DEPTH) || rd_m);
        if (rd_m) void'(q.pop_front());
        if (wr_m) q.push_back(f);
        else if (hv) m_ovf = 1'b1;
        m_halt = (q.size() < DEPTH - SLACK);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        frag_t f;
        frag_t held;
        int    sent;
        int    cyc;

        // Reset held with a hit presented: nothing may be captured.
        hit_valid_in = 1'b1;
        hit_x_in     = 24'h123456;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst = 1'b1;

        f = rand_frag(7);
        f.x = 24'h000400;
        step(1'b1, f, 1'b0);
        chk("first_x", 128'(frag_x), 128'(24'h000400));
        step(1'b0, f, 1'b1);

        // Ordering and halt threshold.
        for (int i = 1; i <= 5; i++) step(1'b1, rand_frag(i), 1'b0);
        chk("occ_after5", 128'(occupancy), 128'(5));
        for (int i = 0; i < 6; i++) step(1'b0, f, 1'b1);

        // Fill, then simultaneous read+write at full, then a dropped hit.
        for (int i = 0; i < DEPTH; i++) step(1'b1, rand_frag(100 + i), 1'b0);
        chk("occ_full", 128'(occupancy), 128'(DEPTH));
        step(1'b1, rand_frag(200), 1'b1);
        chk("full_rw_occ", 128'(occupancy), 128'(DEPTH));
        chk("full_rw_ovf", 128'(overflow_err), 128'(0));
        step(1'b1, rand_frag(201), 1'b0);
        chk("drop_ovf", 128'(overflow_err), 128'(1));
        step(1'b0, f, 1'b0);
        step(1'b0, f, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, f, 1'b1);

        // Wrap-around with a halt-respecting source and toggling ready.
        sent = 0;
        cyc  = 0;
        while ((sent < 20 || q.size() != 0) && cyc < 200) begin
            if (sent < 20 && m_halt) begin
                step(1'b1, rand_frag(300 + sent), (cyc % 2) == 0);
                sent++;
            end else begin
                step(1'b0, f, (cyc % 2) == 0);
            end
            cyc++;
        end
        chk("wrap_done", 128'(cyc < 200), 128'(1));

        // Stall: head must hold for 10 cycles.
        step(1'b1, rand_frag(400), 1'b0);
        held = {frag_x, frag_y, frag_z, frag_color};
        for (int i = 0; i < 10; i++) begin
            step(1'b0, f, 1'b0);
            chk("stall_hold", 128'({frag_x, frag_y, frag_z, frag_color}), 128'(held));
        end
        step(1'b0, f, 1'b1);

        // Mid-stream asynchronous reset at occupancy 6.
        for (int i = 0; i < 6; i++) step(1'b1, rand_frag(500 + i), 1'b0);
        chk("occ_pre_rst", 128'(occupancy), 128'(6));
        hit_valid_in = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        q.delete();
        m_halt = 1'b1;
        m_ovf  = 1'b0;
        check_all();
        chk("rst_frag_x", 128'(frag_x), 128'(0));
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        step(1'b0, f, 1'b1);
        step(1'b1, rand_frag(600), 1'b0);
        step(1'b1, rand_frag(601), 1'b1);
        step(1'b0, f, 1'b1);
        step(1'b0, f, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sample_hit_buffer.md
Name: sample_hit_buffer

Overview:
- Receiving end of the sample-test output interface. It accepts hit fragments (screen x/y, depth z, colour) from the sample pipeline and buffers them in a FIFO.
- Fragments drain to the z-buffer/frame-buffer writer over a valid/ready handshake.
- The block drives the pipeline's active-low halt. Halt is raised early enough to absorb every hit still in flight in the hash and sample stages.

Parameters:
- SIGFIG, 24, bits per coordinate/colour word (from rast_params).
- RADIX, 10, fraction bits. Carried through unchanged; no arithmetic is done on it.
- COLORS, 3, colour channels per fragment.
- DEPTH, 8, FIFO entries. Must be a power of two and at least 2*SLACK.
- SLACK, PIPES_HASH+PIPES_SAMP (=4), number of hits that can still arrive after halt is asserted.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- hit_valid_in  in  1  a hit fragment is presented this cycle (no ready; the source is push-only).
- hit_x_in  in  SIGFIG  sample x, fixed point.
- hit_y_in  in  SIGFIG  sample y, fixed point.
- hit_z_in  in  SIGFIG  sample depth.
- hit_color_in  in  COLORS*SIGFIG  colour, channel 0 in the LSBs.
- halt_L  out  1  0 = upstream must stall.
- frag_valid  out  1  head fragment is available.
- frag_ready  in  1  downstream accepts the head this cycle.
- frag_x  out  SIGFIG  head fragment x.
- frag_y  out  SIGFIG  head fragment y.
- frag_z  out  SIGFIG  head fragment z.
- frag_color  out  COLORS*SIGFIG  head fragment colour.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- overflow_err  out  1  sticky; set when a hit is dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - Outputs: frag_valid=0, halt_L=1, overflow_err=0, occupancy=0.
  - frag_x/y/z/color go to 0. Storage array contents are don't-care.
  - Reset mid-operation discards all stored entries. The first post-reset cycle behaves as empty.
- Read:
  - rd = frag_valid & frag_ready.
  - frag_valid = (count != 0), driven from a register, never from combinational logic on the inputs.
  - frag_* present the head entry (first-word-fall-through). Data must stay stable while frag_valid=1 and frag_ready=0.
- Write:
  - wr = hit_valid_in & ((count < DEPTH) | rd).
  - When full, a simultaneous read and write is accepted and count stays DEPTH.
  - hit_valid_in=1 while count==DEPTH and no read: the hit is dropped, overflow_err is set to 1 and held until reset. Pointers and count are unchanged.
- Latency:
  - A hit written at edge N raises frag_valid after edge N when the FIFO was empty. This is 1 cycle with no bypass.
  - A fragment read at edge N exposes the next entry after edge N.
- Count and pointers:
  - count_next = count + wr - rd. occupancy = count.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Simultaneous write and read on an empty FIFO cannot occur, because rd requires frag_valid.
- Halt:
  - halt_L is a register: halt_L_next = (count_next < DEPTH-SLACK).
  - Halt is asserted at occupancy >= 4 with defaults. It deasserts the cycle after count_next falls below the threshold.
  - With a correct upstream, overflow_err never sets.
- No state machine beyond the FIFO. The block has two conditions, EMPTY (count==0) and FULL (count==DEPTH), and both derive from count.

Decomposition:
- Add the following to rast_params: FRAG_DEPTH=8, and typedef struct packed frag_t {x, y, z: logic[SIGFIG-1:0]; color: logic[COLORS-1:0][SIGFIG-1:0]}.
- Internally, frag_t is the storage word.
- Sub-module frag_fifo (parameterised on DEPTH and frag_t): storage, pointers, count, FWFT head register.
- sample_hit_buffer wraps frag_fifo and adds the halt register and the overflow sticky.

Test Plan:
- Reset: hold rst=0 for 3 cycles with hit_valid_in=1 -> frag_valid=0, halt_L=1, occupancy=0, overflow_err=0. After release, push x=0x000400 -> frag_valid=1 next cycle with frag_x=0x000400.
- Ordering: push 5 hits with z=1..5, frag_ready=0 -> occupancy=5, halt_L=0 after the 4th write. Then set frag_ready=1 -> z drains as 1,2,3,4,5; halt_L=1 once occupancy<4.
- Full plus simultaneous events: fill to 8. Present a hit while frag_ready=1 -> accepted, occupancy stays 8, overflow_err=0. Present a hit with frag_ready=0 -> dropped, overflow_err=1 and sticky.
- Wrap-around: run 20 hits through at 1 hit/cycle with frag_ready toggling 1,0 -> all 20 emerge in order with intact colour channels, and pointers wrap twice.
- Stall hold: frag_valid=1 with frag_ready=0 for 10 cycles -> frag_* bit-stable for all 10 cycles.
- Reset mid-stream: occupancy=6, assert rst asynchronously between edges -> outputs return to reset values immediately, and old data is never emitted.
